inst_encoder: RTL

// - Inverse of the RV32I control decode: packs op ID + rd/rs1/rs2/imm into legal 32-bit RV32I words.
// - Streams encoded words into instruction memory through its write port.
// - Used by the boot/self-test loader to build programs in IMEM before releasing the single-cycle core.
// - Covers the 37 RV32I ops the core executes (R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC).

---
 rtl/inst_encoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs op ID and fields into 32-bit words and streams them into IMEM.
// Optional immediate range checking is enabled by defining INST_ENC_RANGE_CHK_EN.
module inst_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [5:0]        i_op,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    output logic              o_imem_wren,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err
);

    typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;
    typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtJ, FmtU, FmtBad} fmt_e;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [ADDR_W-1:0] BasePtr  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LastSlot = {1'b0, {ADDR_W{1'b1}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d, enc;
    logic              wren_q, wren_d, err_q, err_d;

    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       alt;
    logic       legal, req_ok;

    always_comb begin
        fmt = FmtBad;
        opc = 7'd0;
        f3  = 3'd0;
        alt = 1'b0;
        case (i_op)
            6'd0:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd0; end
            6'd1:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd0; alt = 1'b1; end
            6'd2:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd1; end
            6'd3:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd2; end
            6'd4:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd3; end
            6'd5:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd4; end
            6'd6:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd5; end
            6'd7:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd5; alt = 1'b1; end
            6'd8:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd6; end
            6'd9:  begin fmt = FmtR;  opc = OpcR;      f3 = 3'd7; end
            6'd10: begin fmt = FmtI;  opc = OpcImm;    f3 = 3'd0; end
            6'd11: begin fmt = FmtI;  opc = OpcImm;    f3 = 3'd2; end
            6'd12: begin fmt = FmtI;  opc = OpcImm;    f3 = 3'd3; end
            6'd13: begin fmt = FmtI;  opc = OpcImm;    f3 = 3'd4; end
            6'd14: begin fmt = FmtI;  opc = OpcImm;    f3 = 3'd6; end
            6'd15: begin fmt = FmtI;  opc = OpcImm;    f3 = 3'd7; end
            6'd16: begin fmt = FmtSh; opc = OpcImm;    f3 = 3'd1; end
            6'd17: begin fmt = FmtSh; opc = OpcImm;    f3 = 3'd5; end
            6'd18: begin fmt = FmtSh; opc = OpcImm;    f3 = 3'd5; alt = 1'b1; end
            6'd19: begin fmt = FmtI;  opc = OpcLoad;   f3 = 3'd0; end
            6'd20: begin fmt = FmtI;  opc = OpcLoad;   f3 = 3'd1; end
            6'd21: begin fmt = FmtI;  opc = OpcLoad;   f3 = 3'd2; end
            6'd22: begin fmt = FmtI;  opc = OpcLoad;   f3 = 3'd4; end
            6'd23: begin fmt = FmtI;  opc = OpcLoad;   f3 = 3'd5; end
            6'd24: begin fmt = FmtS;  opc = OpcStore;  f3 = 3'd0; end
            6'd25: begin fmt = FmtS;  opc = OpcStore;  f3 = 3'd1; end
            6'd26: begin fmt = FmtS;  opc = OpcStore;  f3 = 3'd2; end
            6'd27: begin fmt = FmtB;  opc = OpcBranch; f3 = 3'd0; end
            6'd28: begin fmt = FmtB;  opc = OpcBranch; f3 = 3'd1; end
            6'd29: begin fmt = FmtB;  opc = OpcBranch; f3 = 3'd4; end
            6'd30: begin fmt = FmtB;  opc = OpcBranch; f3 = 3'd5; end
            6'd31: begin fmt = FmtB;  opc = OpcBranch; f3 = 3'd6; end
            6'd32: begin fmt = FmtB;  opc = OpcBranch; f3 = 3'd7; end
            6'd33: begin fmt = FmtJ;  opc = OpcJal;    end
            6'd34: begin fmt = FmtI;  opc = OpcJalr;   f3 = 3'd0; end
            6'd35: begin fmt = FmtU;  opc = OpcLui;    end
            6'd36: begin fmt = FmtU;  opc = OpcAuipc;  end
            default: fmt = FmtBad;
        endcase
    end

    always_comb begin
        enc = 32'd0;
        unique case (fmt)
            FmtR:   enc = {1'b0, alt, 5'd0, i_rs2, i_rs1, f3, i_rd, opc};
            FmtI:   enc = {i_imm[11:0], i_rs1, f3, i_rd, opc};
            FmtSh:  enc = {1'b0, alt, 5'd0, i_imm[4:0], i_rs1, f3, i_rd, opc};
            FmtS:   enc = {i_imm[11:5], i_rs2, i_rs1, f3, i_imm[4:0], opc};
            FmtB:   enc = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, f3, i_imm[4:1], i_imm[11], opc};
            FmtJ:   enc = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, opc};
            FmtU:   enc = {i_imm[31:12], i_rd, opc};
            FmtBad: enc = 32'd0;
        endcase
    end

    assign legal = (fmt != FmtBad);

`ifdef INST_ENC_RANGE_CHK_EN
    logic fits12, fits13, fits21, imm_ok;
    assign fits12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign fits13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign fits21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FmtI, FmtS: imm_ok = fits12;
            FmtSh:      imm_ok = ~(|i_imm[31:5]);
            FmtB:       imm_ok = fits13 & ~i_imm[0];
            FmtJ:       imm_ok = fits21 & ~i_imm[0];
            default:    imm_ok = 1'b1;
        endcase
    end

    assign req_ok = legal & imm_ok;
`else
    assign req_ok = legal;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        // Start wins over any same-cycle handshake and cancels the pending write.
        if (i_start) begin
            state_d = StRun;
            ptr_d   = BasePtr;
            count_d = '0;
            err_d   = 1'b0;
        end else if (i_valid && state_q == StRun) begin
            if (req_ok) begin
                wren_d  = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc;
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == LastSlot) begin
                    state_d = StFull;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            ptr_q   <= BasePtr;
            count_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
        end
    end

    assign o_ready      = (state_q == StRun);
    assign o_full       = (state_q == StFull);
    assign o_imem_wren  = wren_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_count      = count_q;
    assign o_err        = err_q;

endmodule
